axi_burst2axil: RTL and testbench

- Converts AXI4 full-protocol bursts into a sequence of single-beat AXI4-Lite transactions.
- Sits between the peripheral master port of the system AXI interconnect and the AXI-Lite-to-IOb bridge that feeds the peripheral split.
- Generates correct RID/BID/RLAST toward the interconnect, so multi-beat CPU accesses to peripherals are legal.
- Handles one transaction at a time, read or write, with fair arbitration between the two.

---
 rtl/axi_burst2axil.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_axi_burst2axil.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst2axil.sv
// axi_burst2axil: AXI4 burst slave to AXI4-Lite single-beat master.
// One burst (read or write) is in flight at a time. Each AXI4 beat becomes one
// Lite transaction. Write responses are folded into a single B. Read data is
// returned beat by beat with RID/RLAST regenerated.
module axi_burst2axil #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // AXI4 slave: write address
  input  logic [ID_W-1:0]       s_axi_awid_i,
  input  logic [ADDR_W-1:0]     s_axi_awaddr_i,
  input  logic [LEN_W-1:0]      s_axi_awlen_i,
  input  logic [2:0]            s_axi_awsize_i,
  input  logic [1:0]            s_axi_awburst_i,
  input  logic                  s_axi_awlock_i,
  input  logic [3:0]            s_axi_awcache_i,
  input  logic [2:0]            s_axi_awprot_i,
  input  logic [3:0]            s_axi_awqos_i,
  input  logic                  s_axi_awvalid_i,
  output logic                  s_axi_awready_o,
  // AXI4 slave: write data
  input  logic [DATA_W-1:0]     s_axi_wdata_i,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb_i,
  input  logic                  s_axi_wlast_i,
  input  logic                  s_axi_wvalid_i,
  output logic                  s_axi_wready_o,
  // AXI4 slave: write response
  output logic [ID_W-1:0]       s_axi_bid_o,
  output logic [1:0]            s_axi_bresp_o,
  output logic                  s_axi_bvalid_o,
  input  logic                  s_axi_bready_i,
  // AXI4 slave: read address
  input  logic [ID_W-1:0]       s_axi_arid_i,
  input  logic [ADDR_W-1:0]     s_axi_araddr_i,
  input  logic [LEN_W-1:0]      s_axi_arlen_i,
  input  logic [2:0]            s_axi_arsize_i,
  input  logic [1:0]            s_axi_arburst_i,
  input  logic                  s_axi_arlock_i,
  input  logic [3:0]            s_axi_arcache_i,
  input  logic [2:0]            s_axi_arprot_i,
  input  logic [3:0]            s_axi_arqos_i,
  input  logic                  s_axi_arvalid_i,
  output logic                  s_axi_arready_o,
  // AXI4 slave: read data
  output logic [ID_W-1:0]       s_axi_rid_o,
  output logic [DATA_W-1:0]     s_axi_rdata_o,
  output logic [1:0]            s_axi_rresp_o,
  output logic                  s_axi_rlast_o,
  output logic                  s_axi_rvalid_o,
  input  logic                  s_axi_rready_i,
  // AXI4-Lite master: write address
  output logic [ADDR_W-1:0]     m_axil_awaddr_o,
  output logic [2:0]            m_axil_awprot_o,
  output logic                  m_axil_awvalid_o,
  input  logic                  m_axil_awready_i,
  // AXI4-Lite master: write data
  output logic [DATA_W-1:0]     m_axil_wdata_o,
  output logic [DATA_W/8-1:0]   m_axil_wstrb_o,
  output logic                  m_axil_wvalid_o,
  input  logic                  m_axil_wready_i,
  // AXI4-Lite master: write response
  input  logic [1:0]            m_axil_bresp_i,
  input  logic                  m_axil_bvalid_i,
  output logic                  m_axil_bready_o,
  // AXI4-Lite master: read address
  output logic [ADDR_W-1:0]     m_axil_araddr_o,
  output logic [2:0]            m_axil_arprot_o,
  output logic                  m_axil_arvalid_o,
  input  logic                  m_axil_arready_i,
  // AXI4-Lite master: read data
  input  logic [DATA_W-1:0]     m_axil_rdata_i,
  input  logic [1:0]            m_axil_rresp_i,
  input  logic                  m_axil_rvalid_i,
  output logic                  m_axil_rready_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_BEAT  = 3'd1,
    S_W_LITE  = 3'd2,
    S_W_BRESP = 3'd3,
    S_W_B     = 3'd4,
    S_R_LITE  = 3'd5,
    S_R_WAIT  = 3'd6,
    S_R_OUT   = 3'd7
  } state_e;

  // Next beat address: FIXED holds, everything else steps by the beat size
  // and wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0]        size,
                                                  input logic [1:0]        burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] res;
    step = ADDR_W'(1'b1) << size;
    if (burst == BURST_FIXED) begin
      res = addr;
    end else begin
      res = addr + step;
    end
    return res;
  endfunction

  // Response severity ordering matches the encoding, so the worst response is the maximum.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] m;
    if (a >= b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

  state_e              state_q, state_d;
  logic                last_wr_q, last_wr_d;   // 1: last served burst was a write
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic grant_wr_s;
  logic grant_rd_s;
  logic aw_fin_s;
  logic w_fin_s;
  logic last_beat_s;
  logic unused_s;

  // Fair arbitration: a lone request wins; on contention the channel not served last wins.
  assign grant_wr_s = s_axi_awvalid_i & (~s_axi_arvalid_i | ~last_wr_q);
  assign grant_rd_s = s_axi_arvalid_i & (~s_axi_awvalid_i | last_wr_q);

  // Lite AW/W complete independently; a channel is finished once done earlier or handshaking now.
  assign aw_fin_s    = aw_done_q | m_axil_awready_i;
  assign w_fin_s     = w_done_q | m_axil_wready_i;
  assign last_beat_s = (beat_q == len_q);

  // Sideband fields and WLAST carry no meaning here; beat count comes from AxLEN.
  assign unused_s = ^{s_axi_wlast_i, s_axi_awlock_i, s_axi_awcache_i, s_axi_awprot_i,
                      s_axi_awqos_i, s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i,
                      s_axi_arqos_i};

  // Upstream address readies are the only combinational paths; masked while in reset.
  assign s_axi_awready_o = (state_q == S_IDLE) & grant_wr_s & ~rst_i;
  assign s_axi_arready_o = (state_q == S_IDLE) & grant_rd_s & ~rst_i;

  assign s_axi_wready_o  = (state_q == S_W_BEAT);
  assign s_axi_bid_o     = id_q;
  assign s_axi_bresp_o   = bresp_q;
  assign s_axi_bvalid_o  = (state_q == S_W_B);
  assign s_axi_rid_o     = id_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = rresp_q;
  assign s_axi_rlast_o   = (state_q == S_R_OUT) & last_beat_s;
  assign s_axi_rvalid_o  = (state_q == S_R_OUT);

  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = (state_q == S_W_LITE) & ~aw_done_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = wstrb_q;
  assign m_axil_wvalid_o  = (state_q == S_W_LITE) & ~w_done_q;
  assign m_axil_bready_o  = (state_q == S_W_BRESP);
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = (state_q == S_R_LITE);
  assign m_axil_rready_o  = (state_q == S_R_WAIT);

  // Next-state and datapath update for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    bresp_d   = bresp_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (grant_wr_s) begin
          id_d    = s_axi_awid_i;
          addr_d  = s_axi_awaddr_i;
          len_d   = s_axi_awlen_i;
          size_d  = s_axi_awsize_i;
          burst_d = s_axi_awburst_i;
          beat_d  = {LEN_W{1'b0}};
          bresp_d = 2'b00;
          state_d = S_W_BEAT;
        end else if (grant_rd_s) begin
          id_d    = s_axi_arid_i;
          addr_d  = s_axi_araddr_i;
          len_d   = s_axi_arlen_i;
          size_d  = s_axi_arsize_i;
          burst_d = s_axi_arburst_i;
          beat_d  = {LEN_W{1'b0}};
          bresp_d = 2'b00;
          state_d = S_R_LITE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_W_BEAT: begin
        if (s_axi_wvalid_i) begin
          wdata_d   = s_axi_wdata_i;
          wstrb_d   = s_axi_wstrb_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_W_LITE;
        end else begin
          state_d = S_W_BEAT;
        end
      end

      S_W_LITE: begin
        aw_done_d = aw_fin_s;
        w_done_d  = w_fin_s;
        if (aw_fin_s && w_fin_s) begin
          state_d = S_W_BRESP;
        end else begin
          state_d = S_W_LITE;
        end
      end

      S_W_BRESP: begin
        if (m_axil_bvalid_i) begin
          bresp_d = resp_max(bresp_q, m_axil_bresp_i);
          if (last_beat_s) begin
            state_d = S_W_B;
          end else begin
            addr_d  = next_addr(addr_q, size_q, burst_q);
            beat_d  = beat_q + LEN_W'(1'b1);
            state_d = S_W_BEAT;
          end
        end else begin
          state_d = S_W_BRESP;
        end
      end

      S_W_B: begin
        if (s_axi_bready_i) begin
          last_wr_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_W_B;
        end
      end

      S_R_LITE: begin
        if (m_axil_arready_i) begin
          state_d = S_R_WAIT;
        end else begin
          state_d = S_R_LITE;
        end
      end

      S_R_WAIT: begin
        if (m_axil_rvalid_i) begin
          rdata_d = m_axil_rdata_i;
          rresp_d = m_axil_rresp_i;
          state_d = S_R_OUT;
        end else begin
          state_d = S_R_WAIT;
        end
      end

      S_R_OUT: begin
        if (s_axi_rready_i) begin
          if (last_beat_s) begin
            last_wr_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            addr_d  = next_addr(addr_q, size_q, burst_q);
            beat_d  = beat_q + LEN_W'(1'b1);
            state_d = S_R_LITE;
          end
        end else begin
          state_d = S_R_OUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b1;
      id_q      <= {ID_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      len_q     <= {LEN_W{1'b0}};
      size_q    <= 3'b000;
      burst_q   <= 2'b00;
      beat_q    <= {LEN_W{1'b0}};
      bresp_q   <= 2'b00;
      wdata_q   <= {DATA_W{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      rresp_q   <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      bresp_q   <= bresp_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_burst2axil.sv
// tb_axi_burst2axil: directed plus randomized bursts against a queue-based Lite slave.
module tb_axi_burst2axil;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 1;
  localparam int LEN_W  = 8;

  logic clk;
  logic rst_i;

  // Upstream master drives
  logic [ID_W-1:0]  awid, arid;
  logic [31:0]      awaddr, araddr;
  logic [7:0]       awlen, arlen;
  logic [2:0]       awsize, arsize;
  logic [1:0]       awburst, arburst;
  logic             awvalid, arvalid;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             wlast, wvalid, bready, rready;
  // Upstream DUT outputs
  logic             s_awready, s_wready, s_arready;
  logic [ID_W-1:0]  s_bid, s_rid;
  logic [1:0]       s_bresp, s_rresp;
  logic             s_bvalid, s_rvalid, s_rlast;
  logic [31:0]      s_rdata;
  // Downstream DUT outputs
  logic [31:0]      m_awaddr, m_wdata, m_araddr;
  logic [2:0]       m_awprot, m_arprot;
  logic [3:0]       m_wstrb;
  logic             m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  // Lite slave model drives
  logic             m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]       m_bresp, m_rresp;
  logic [31:0]      m_rdata;

  // Lite slave records and planned responses
  logic [31:0] lite_aw_q[$];
  logic [31:0] lite_w_q[$];
  logic [3:0]  lite_strb_q[$];
  logic [31:0] lite_ar_q[$];
  logic [1:0]  bresp_plan_q[$];
  logic [31:0] rdata_plan_q[$];
  logic [1:0]  rresp_plan_q[$];

  // Per-burst stimulus tables
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  logic [1:0]  br[16];
  logic [31:0] rd[16];
  logic [1:0]  rr[16];

  int checks;
  int passes;
  int fails;

  axi_burst2axil #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_axi_awid_i(awid), .s_axi_awaddr_i(awaddr), .s_axi_awlen_i(awlen),
    .s_axi_awsize_i(awsize), .s_axi_awburst_i(awburst), .s_axi_awlock_i(1'b0),
    .s_axi_awcache_i(4'h0), .s_axi_awprot_i(3'h0), .s_axi_awqos_i(4'h0),
    .s_axi_awvalid_i(awvalid), .s_axi_awready_o(s_awready),
    .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(s_wready),
    .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid),
    .s_axi_bready_i(bready),
    .s_axi_arid_i(arid), .s_axi_araddr_i(araddr), .s_axi_arlen_i(arlen),
    .s_axi_arsize_i(arsize), .s_axi_arburst_i(arburst), .s_axi_arlock_i(1'b0),
    .s_axi_arcache_i(4'h0), .s_axi_arprot_i(3'h0), .s_axi_arqos_i(4'h0),
    .s_axi_arvalid_i(arvalid), .s_axi_arready_o(s_arready),
    .s_axi_rid_o(s_rid), .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp),
    .s_axi_rlast_o(s_rlast), .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(rready),
    .m_axil_awaddr_o(m_awaddr), .m_axil_awprot_o(m_awprot), .m_axil_awvalid_o(m_awvalid),
    .m_axil_awready_i(m_awready),
    .m_axil_wdata_o(m_wdata), .m_axil_wstrb_o(m_wstrb), .m_axil_wvalid_o(m_wvalid),
    .m_axil_wready_i(m_wready),
    .m_axil_bresp_i(m_bresp), .m_axil_bvalid_i(m_bvalid), .m_axil_bready_o(m_bready),
    .m_axil_araddr_o(m_araddr), .m_axil_arprot_o(m_arprot), .m_axil_arvalid_o(m_arvalid),
    .m_axil_arready_i(m_arready),
    .m_axil_rdata_i(m_rdata), .m_axil_rresp_i(m_rresp), .m_axil_rvalid_i(m_rvalid),
    .m_axil_rready_o(m_rready)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference address of beat i: FIXED repeats the base, all else steps by 2**size mod 2**32.
  function automatic logic [31:0] ref_addr(input logic [31:0] base, input logic [2:0] size,
                                           input logic [1:0] burst, input int i);
    logic [31:0] off;
    if (burst == 2'b00) return base;
    off = (32'd1 << size) * 32'(i);
    return base + off;
  endfunction

  // Lite slave: record handshakes at negedge, update outputs just after posedge.
  initial begin
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, rst_seen;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      rst_seen = rst_i;
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      ar_hs = m_arvalid && m_arready;
      b_hs  = m_bvalid && m_bready;
      r_hs  = m_rvalid && m_rready;
      if (aw_hs) lite_aw_q.push_back(m_awaddr);
      if (w_hs) begin lite_w_q.push_back(m_wdata); lite_strb_q.push_back(m_wstrb); end
      if (ar_hs) lite_ar_q.push_back(m_araddr);
      @(posedge clk); #1;
      if (rst_seen) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        lite_aw_q.delete(); lite_w_q.delete(); lite_strb_q.delete(); lite_ar_q.delete();
        bresp_plan_q.delete(); rdata_plan_q.delete(); rresp_plan_q.delete();
      end else begin
        if (aw_hs) aw_cnt++;
        if (w_hs) w_cnt++;
        if (ar_hs) ar_cnt++;
        if (b_hs) begin m_bvalid = 1'b0; b_cnt++; end
        if (r_hs) begin m_rvalid = 1'b0; r_cnt++; end
        if (!m_bvalid && b_cnt < aw_cnt && b_cnt < w_cnt && $urandom_range(0, 2) != 0) begin
          m_bvalid = 1'b1;
          if (bresp_plan_q.size() > 0) m_bresp = bresp_plan_q.pop_front();
          else m_bresp = 2'b00;
        end
        if (!m_rvalid && r_cnt < ar_cnt && $urandom_range(0, 2) != 0) begin
          m_rvalid = 1'b1;
          if (rdata_plan_q.size() > 0) begin
            m_rdata = rdata_plan_q.pop_front();
            m_rresp = rresp_plan_q.pop_front();
          end else begin
            m_rdata = 32'h0; m_rresp = 2'b00;
          end
        end
        m_awready = ($urandom_range(0, 3) != 0);
        m_wready  = ($urandom_range(0, 3) != 0);
        m_arready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic do_aw(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_handshake", 64'(ok), 64'd1);
  endtask

  task automatic do_ar(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 1'b0;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("ar_handshake", 64'(ok), 64'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic do_b(output logic [ID_W-1:0] id, output logic [1:0] resp);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_bvalid) begin ok = 1'b1; break; end
    end
    id = s_bid; resp = s_bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_handshake", 64'(ok), 64'd1);
  endtask

  task automatic do_r(output logic [31:0] d, output logic [1:0] resp, output logic l,
                      output logic [ID_W-1:0] id);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_rvalid) begin ok = 1'b1; break; end
    end
    d = s_rdata; resp = s_rresp; l = s_rlast; id = s_rid;
    @(posedge clk); #1;
    rready = 1'b0;
    check("r_handshake", 64'(ok), 64'd1);
  endtask

  // Hold RREADY low for five cycles once RVALID shows; data must stay put, no new Lite AR.
  task automatic stall_check(input string tag);
    bit ok;
    logic [31:0] d0;
    int ar_n;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_rvalid) begin ok = 1'b1; break; end
    end
    check({tag, "_stall_rvalid_seen"}, 64'(ok), 64'd1);
    d0 = s_rdata;
    @(posedge clk); #2;
    ar_n = lite_ar_q.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check({tag, "_stall_rvalid"}, 64'(s_rvalid), 64'd1);
      check({tag, "_stall_rdata"}, 64'(s_rdata), 64'(d0));
      @(posedge clk); #2;
      check({tag, "_stall_no_ar"}, 64'(lite_ar_q.size()), 64'(ar_n));
    end
    #1;  // realign to posedge + #1 would be lost; wait for next edge instead
    @(posedge clk); #1;
  endtask

  task automatic write_burst(input string tag, input logic [ID_W-1:0] id, input logic [31:0] a,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ID_W-1:0] bid;
    logic [1:0] bresp;
    logic [1:0] exp_resp;
    lite_aw_q.delete(); lite_w_q.delete(); lite_strb_q.delete();
    exp_resp = 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      bresp_plan_q.push_back(br[i]);
      if (br[i] > exp_resp) exp_resp = br[i];
    end
    do_aw(id, a, len, size, burst);
    for (int i = 0; i <= int'(len); i++) do_w(wd[i], ws[i], (i == int'(len)));
    do_b(bid, bresp);
    check({tag, "_bid"}, 64'(bid), 64'(id));
    check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    check({tag, "_aw_count"}, 64'(lite_aw_q.size()), 64'(int'(len) + 1));
    check({tag, "_w_count"}, 64'(lite_w_q.size()), 64'(int'(len) + 1));
    for (int i = 0; i <= int'(len) && i < lite_aw_q.size() && i < lite_w_q.size(); i++) begin
      check({tag, "_awaddr"}, 64'(lite_aw_q[i]), 64'(ref_addr(a, size, burst, i)));
      check({tag, "_wdata"}, 64'(lite_w_q[i]), 64'(wd[i]));
      check({tag, "_wstrb"}, 64'(lite_strb_q[i]), 64'(ws[i]));
    end
  endtask

  task automatic read_burst(input string tag, input logic [ID_W-1:0] id, input logic [31:0] a,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat);
    logic [31:0] d;
    logic [1:0] r;
    logic l;
    logic [ID_W-1:0] rid;
    lite_ar_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      rdata_plan_q.push_back(rd[i]);
      rresp_plan_q.push_back(rr[i]);
    end
    do_ar(id, a, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) stall_check(tag);
      do_r(d, r, l, rid);
      check({tag, "_rdata"}, 64'(d), 64'(rd[i]));
      check({tag, "_rresp"}, 64'(r), 64'(rr[i]));
      check({tag, "_rlast"}, 64'(l), 64'(i == int'(len)));
      check({tag, "_rid"}, 64'(rid), 64'(id));
    end
    check({tag, "_ar_count"}, 64'(lite_ar_q.size()), 64'(int'(len) + 1));
    for (int i = 0; i <= int'(len) && i < lite_ar_q.size(); i++)
      check({tag, "_araddr"}, 64'(lite_ar_q[i]), 64'(ref_addr(a, size, burst, i)));
  endtask

  // Directed then randomized stimulus
  initial begin
    logic [31:0] d;
    logic [1:0] r;
    logic l;
    logic [ID_W-1:0] id;
    bit ok;
    checks = 0; passes = 0; fails = 0;
    rst_i = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_wready", 64'(s_wready), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_rvalid), 64'd0);
    check("rst_rlast", 64'(s_rlast), 64'd0);
    check("rst_bid_bresp", 64'({s_bid, s_bresp}), 64'd0);
    check("rst_rdata", 64'(s_rdata), 64'd0);
    check("rst_lite_valids", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    check("rst_lite_readies", 64'({m_bready, m_rready}), 64'd0);
    check("rst_lite_addr", 64'({m_awaddr, m_araddr}), 64'd0);
    check("rst_lite_wdata", 64'(m_wdata), 64'd0);
    check("rst_prot", 64'({m_awprot, m_arprot}), 64'd0);
    @(posedge clk); #1;

    // Contention right after reset: read first, then write
    lite_aw_q.delete(); lite_ar_q.delete(); lite_w_q.delete(); lite_strb_q.delete();
    rdata_plan_q.push_back(32'hA5A5_0001); rresp_plan_q.push_back(2'b00);
    bresp_plan_q.push_back(2'b00);
    awid = 1'b1; awaddr = 32'h300; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    arid = 1'b0; araddr = 32'h400; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    check("arb_arready_first", 64'(s_arready), 64'd1);
    check("arb_awready_held", 64'(s_awready), 64'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    do_r(d, r, l, id);
    check("arb_rdata", 64'(d), 64'hA5A5_0001);
    check("arb_rlast", 64'(l), 64'd1);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_awready) begin ok = 1'b1; break; end
    end
    check("arb_aw_after_read", 64'(ok), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    do_w(32'h1234_5678, 4'hF, 1'b1);
    do_b(id, r);
    check("arb_bid", 64'(id), 64'd1);
    check("arb_bresp", 64'(r), 64'd0);
    check("arb_lite_ar", 64'(lite_ar_q[0]), 64'h400);
    check("arb_lite_aw", 64'(lite_aw_q[0]), 64'h300);

    // Single write
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; br[0] = 2'b00;
    write_burst("single_wr", 1'b1, 32'h100, 8'd0, 3'd2, 2'b01);

    // INCR read burst with backpressure on beat 1
    for (int i = 0; i < 4; i++) begin rd[i] = 32'(i + 1); rr[i] = 2'b00; end
    read_burst("incr_rd", 1'b1, 32'h200, 8'd3, 3'd2, 2'b01, 1);

    // Error accumulation
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    br[0] = 2'b00; br[1] = 2'b10; br[2] = 2'b00;
    write_burst("err_acc", 1'b0, 32'h80, 8'd2, 3'd2, 2'b01);

    // FIXED burst
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'(i + 1); br[i] = 2'b00; end
    write_burst("fixed_wr", 1'b0, 32'h40, 8'd2, 3'd2, 2'b00);

    // INCR wrap past all-ones
    rd[0] = 32'hCAFE_0000; rd[1] = 32'hCAFE_0001; rr[0] = 2'b00; rr[1] = 2'b11;
    read_burst("wrap_rd", 1'b0, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, -1);

    // Mid-burst reset during the third beat of a four-beat read
    lite_ar_q.delete();
    for (int i = 0; i < 4; i++) begin
      rdata_plan_q.push_back(32'h5000 + 32'(i)); rresp_plan_q.push_back(2'b00);
    end
    do_ar(1'b1, 32'h500, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      do_r(d, r, l, id);
      check("mid_rst_pre_rdata", 64'(d), 64'(32'h5000 + 32'(i)));
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_s_valids", 64'({s_bvalid, s_rvalid, s_wready}), 64'd0);
    check("mid_rst_lite_valids", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'd0);
    check("mid_rst_lite_readies", 64'({m_bready, m_rready}), 64'd0);
    @(posedge clk); #1;
    rd[0] = 32'h6666_0000; rr[0] = 2'b01;
    read_burst("post_rst_rd", 1'b0, 32'h600, 8'd0, 3'd2, 2'b01, -1);

    // Randomized bursts
    for (int t = 0; t < 16; t++) begin
      logic [31:0] a;
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      logic [ID_W-1:0] rid;
      a = $urandom; len = 8'($urandom_range(0, 4)); size = 3'($urandom_range(0, 2));
      burst = 2'($urandom_range(0, 3)); rid = ID_W'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom; ws[i] = 4'($urandom); br[i] = 2'($urandom);
        rd[i] = $urandom; rr[i] = 2'($urandom);
      end
      if ($urandom_range(0, 1) == 0) write_burst("rand_wr", rid, a, len, size, burst);
      else read_burst("rand_rd", rid, a, len, size, burst, -1);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
